prn_data_gen_axis: RTL and testbench

- Multi-channel pseudo-random data generator for the OTFS transmit chain.
- Configured over an AXI4-Lite slave: control, seed, frame length and status registers.
- Emits framed PRBS words on an AXI4-Stream master that feeds the symbol mapper.
- Successor to the single-channel, register-only generator: adds a parametrised lane count, lane width and LFSR polynomial, streaming output with backpressure and framing, and one-shot mode.

---
 rtl/prn_data_gen_axis.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_prn_data_gen_axis.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prn_data_gen_axis.sv
// prn_data_gen_axis
//   Multi-channel PRBS generator for the OTFS transmit chain. NUM_CH Fibonacci
//   LFSR lanes each contribute BITS_PER_CH bits per AXI4-Stream beat. They are
//   configured through a 4-register AXI4-Lite slave.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*        AXI4-Lite write channel (one transaction in flight)
//   s_axi_ar*/r*           AXI4-Lite read channel (one transaction in flight)
//   m_axis_tdata/tvalid    PRBS beat, lane k on bits [k*BITS_PER_CH +: BITS_PER_CH]
//   m_axis_tready          sink backpressure
//   m_axis_tlast           last beat of a FRAME_LEN-beat frame
//
// Register map (byte address, bits [3:2] decode)
//   0x0 CTRL      bit0 ENABLE, bit1 LOAD (self-clearing), bit2 ONESHOT
//   0x4 SEED      [LFSR_W-1:0]
//   0x8 FRAME_LEN [15:0], 0 behaves as 1
//   0xC STATUS    bit0 RUNNING, bit1 DONE, [31:16] frame count (read-only)
module prn_data_gen_axis #(
  parameter int                NUM_CH      = 4,
  parameter int                BITS_PER_CH = 8,
  parameter int                LFSR_W      = 31,
  parameter logic [LFSR_W-1:0] POLY        = 31'h48000000,
  parameter int                DATA_W      = NUM_CH * BITS_PER_CH
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [3:0]        s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [3:0]        s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

  // Advance one lane by BITS_PER_CH Fibonacci steps in a single cycle.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] v;
    logic              fb;
    v = s;
    for (int i = 0; i < BITS_PER_CH; i++) begin
      fb = ^(v & POLY);
      v  = {v[LFSR_W-2:0], fb};
    end
    return v;
  endfunction

  // Per-lane seed; the all-zero lock-up state is replaced by 1.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] seed, input int k);
    logic [31:0]       kx;
    logic [LFSR_W-1:0] v;
    kx = 32'(k) << 8;
    v  = seed ^ kx[LFSR_W-1:0];
    if (v == {LFSR_W{1'b0}}) begin
      v = LFSR_ONE;
    end
    return v;
  endfunction

  // Byte-enable merge of a write into a register's current read value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      else         r[8*b +: 8] = old_v[8*b +: 8];
    end
    return r;
  endfunction

  // Registers
  logic              r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0]       r_rdata;
  logic              r_enable, r_oneshot, r_done, r_load_pend;
  logic [LFSR_W-1:0] r_seed;
  logic [15:0]       r_frame_len, r_len_shadow, r_beat_cnt, r_frame_cnt;
  logic [LFSR_W-1:0] r_lane [NUM_CH];
  state_t            r_state;

  // Combinational
  state_t            w_state_nxt;
  logic              w_wr_fire, w_rd_fire, w_load_req, w_load_now, w_load_pend_nxt;
  logic              w_tvalid, w_tlast, w_hs;
  logic [15:0]       w_len_eff;
  logic [31:0]       w_ctrl_rd, w_seed_rd, w_len_rd, w_status_rd;
  logic [31:0]       w_wr_cur, w_wr_new, w_rd_val;
  logic [DATA_W-1:0] w_tdata;
  logic              w_unused;

  assign w_ctrl_rd   = {29'd0, r_oneshot, 1'b0, r_enable};
  assign w_seed_rd   = 32'(r_seed);
  assign w_len_rd    = {16'd0, r_frame_len};
  assign w_status_rd = {r_frame_cnt, 14'd0, r_done, (r_state == ST_RUN)};

  assign w_wr_fire = r_awready & s_axi_awvalid & s_axi_wvalid;
  assign w_rd_fire = r_arready & s_axi_arvalid;
  assign w_tvalid  = (r_state == ST_RUN);
  assign w_hs      = w_tvalid & m_axis_tready;
  assign w_load_req = w_wr_fire & (s_axi_awaddr[3:2] == 2'd0) & w_wr_new[1];
  // A pending LOAD must not disturb a beat the sink has not yet taken.
  assign w_load_now = (w_load_req | r_load_pend) & ~(w_tvalid & ~m_axis_tready);
  assign w_unused   = ^{w_wr_new, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Register-select muxes for write merge and read data
  always_comb begin
    w_wr_cur = 32'd0;
    w_rd_val = 32'd0;
    case (s_axi_awaddr[3:2])
      2'd0:    w_wr_cur = w_ctrl_rd;
      2'd1:    w_wr_cur = w_seed_rd;
      2'd2:    w_wr_cur = w_len_rd;
      default: w_wr_cur = w_status_rd;
    endcase
    case (s_axi_araddr[3:2])
      2'd0:    w_rd_val = w_ctrl_rd;
      2'd1:    w_rd_val = w_seed_rd;
      2'd2:    w_rd_val = w_len_rd;
      default: w_rd_val = w_status_rd;
    endcase
  end

  assign w_wr_new = apply_strb(w_wr_cur, s_axi_wdata, s_axi_wstrb);

  // Effective frame length, tlast, pending-LOAD tracking and lane data gating
  always_comb begin
    w_len_eff       = r_frame_len;
    w_load_pend_nxt = r_load_pend;
    w_tdata         = {DATA_W{1'b0}};
    if (r_frame_len == 16'd0) w_len_eff = 16'd1;
    else                      w_len_eff = r_frame_len;
    w_tlast = w_tvalid & (r_beat_cnt == (r_len_shadow - 16'd1));
    if (w_load_now)      w_load_pend_nxt = 1'b0;
    else if (w_load_req) w_load_pend_nxt = 1'b1;
    else                 w_load_pend_nxt = r_load_pend;
    if (w_tvalid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        w_tdata[k*BITS_PER_CH +: BITS_PER_CH] = r_lane[k][BITS_PER_CH-1:0];
      end
    end else begin
      w_tdata = {DATA_W{1'b0}};
    end
  end

  // Next-state logic; LOAD overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_enable) w_state_nxt = ST_RUN;
        else          w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_hs && w_tlast && r_oneshot) w_state_nxt = ST_DONE;
        else if (w_hs && !r_enable)       w_state_nxt = ST_IDLE;
        else                              w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load_now) w_state_nxt = ST_IDLE;
    else            w_state_nxt = w_state_nxt;
  end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // AXI4-Lite handshakes and registered read data
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_awready <= ~r_awready & ~r_bvalid & s_axi_awvalid & s_axi_wvalid;
      if (w_wr_fire)         r_bvalid <= 1'b1;
      else if (s_axi_bready) r_bvalid <= 1'b0;
      r_arready <= ~r_arready & ~r_rvalid & s_axi_arvalid;
      if (w_rd_fire) begin
        r_rdata  <= w_rd_val;
        r_rvalid <= 1'b1;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Configuration registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_enable    <= 1'b0;
      r_oneshot   <= 1'b0;
      r_seed      <= LFSR_ONE;
      r_frame_len <= 16'd1;
    end else if (w_wr_fire) begin
      case (s_axi_awaddr[3:2])
        2'd0: begin
          r_enable  <= w_wr_new[0];
          r_oneshot <= w_wr_new[2];
        end
        2'd1:    r_seed      <= w_wr_new[LFSR_W-1:0];
        2'd2:    r_frame_len <= w_wr_new[15:0];
        default: r_seed      <= r_seed;
      endcase
    end
  end

  // Lane state, beat/frame counters, DONE flag and frame-length shadow
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_CH; k++) r_lane[k] <= lane_seed(LFSR_ONE, k);
      r_beat_cnt   <= 16'd0;
      r_frame_cnt  <= 16'd0;
      r_done       <= 1'b0;
      r_len_shadow <= 16'd1;
      r_load_pend  <= 1'b0;
    end else begin
      r_load_pend <= w_load_pend_nxt;
      if (w_load_now) begin
        for (int k = 0; k < NUM_CH; k++) r_lane[k] <= lane_seed(r_seed, k);
        r_beat_cnt   <= 16'd0;
        r_frame_cnt  <= 16'd0;
        r_done       <= 1'b0;
        r_len_shadow <= w_len_eff;
      end else if (w_hs) begin
        for (int k = 0; k < NUM_CH; k++) r_lane[k] <= lfsr_advance(r_lane[k]);
        if (w_tlast) begin
          r_beat_cnt   <= 16'd0;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
          r_len_shadow <= w_len_eff;
          if (r_oneshot) r_done <= 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end else if ((r_state != ST_RUN) && (r_beat_cnt == 16'd0)) begin
        // Track FRAME_LEN while parked at a frame boundary.
        r_len_shadow <= w_len_eff;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_awready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign m_axis_tdata  = w_tdata;

endmodule

// File: tb/tb_prn_data_gen_axis.sv
// Directed testbench for prn_data_gen_axis (default parameters: 4 lanes x 8 bits, PRBS31).
module tb_prn_data_gen_axis;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  s_axi_awaddr = 4'd0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 32'd0;
  logic [3:0]  s_axi_wstrb = 4'd0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = 4'd0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_d [0:7];
  logic        exp_l [0:7];
  logic [31:0] rd;

  prn_data_gen_axis dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok;
    @(posedge ACLK); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (s_axi_awready && s_axi_wready) ok = 1'b1;
    end
    check("aw_w_ready", 32'(ok), 32'd1);
    @(posedge ACLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (s_axi_bvalid) ok = 1'b1;
    end
    check("bvalid", 32'(ok), 32'd1);
    check("bresp", 32'(s_axi_bresp), 32'd0);
    @(posedge ACLK); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit ok;
    @(posedge ACLK); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (s_axi_arready) ok = 1'b1;
    end
    check("arready", 32'(ok), 32'd1);
    @(posedge ACLK); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    ok = 1'b0;
    data = 32'hDEADBEEF;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (s_axi_rvalid) begin
        ok = 1'b1;
        data = s_axi_rdata;
      end
    end
    check("rvalid", 32'(ok), 32'd1);
    check("rresp", 32'(s_axi_rresp), 32'd0);
    @(posedge ACLK); #1;
    s_axi_rready = 1'b0;
  endtask

  // Accept n beats against exp_d/exp_l; toggle=1 drives tready 1,0,1,0...
  task automatic collect(input int n, input bit toggle, input string tag);
    int          got;
    int          cyc;
    logic [31:0] held_d;
    logic        held_l;
    bit          pend;
    got = 0; cyc = 0; pend = 1'b0; held_d = 32'd0; held_l = 1'b0;
    while (got < n && cyc < 100) begin
      m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge ACLK);
      if (pend) begin
        check({tag, "_hold_valid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_hold_data"}, m_axis_tdata, held_d);
        check({tag, "_hold_last"}, 32'(m_axis_tlast), 32'(held_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check({tag, "_data"}, m_axis_tdata, exp_d[got]);
        check({tag, "_last"}, 32'(m_axis_tlast), 32'(exp_l[got]));
        got++;
        pend = 1'b0;
      end else if (m_axis_tvalid) begin
        held_d = m_axis_tdata;
        held_l = m_axis_tlast;
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    if (!toggle) check({tag, "_cycles"}, 32'(cyc), 32'(n));
  endtask

  // Drain one held beat after ENABLE has been cleared, then expect idle.
  task automatic drain_and_stop(input string tag);
    m_axis_tready = 1'b1;
    @(posedge ACLK); #1;
    m_axis_tready = 1'b0;
    @(negedge ACLK);
    check({tag, "_idle"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    // ---- 1: reset values and register access ----
    repeat (3) @(negedge ACLK);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    ARESETN = 1'b1;
    axi_read(4'h0, rd); check("t1_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("t1_seed", rd, 32'h1);
    axi_read(4'h8, rd); check("t1_len", rd, 32'h1);
    axi_read(4'hC, rd); check("t1_status", rd, 32'h0);
    axi_write(4'h4, 32'h12345678, 4'b0101);
    axi_read(4'h4, rd); check("t1_seed_strb", rd, 32'h00340078);
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axi_read(4'h4, rd); check("t1_seed_width", rd, 32'h7FFFFFFF);
    axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_read(4'hC, rd); check("t1_status_ro", rd, 32'h0);
    // FRAME_LEN=0 behaves as 1: every beat carries tlast
    axi_write(4'h4, 32'h1, 4'hF);
    axi_write(4'h8, 32'h0, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    exp_d[0] = 32'h01010101; exp_l[0] = 1'b1;
    exp_d[1] = 32'h00000000; exp_l[1] = 1'b1;
    collect(2, 1'b0, "t1_len0");
    m_axis_tready = 1'b0;
    axi_read(4'hC, rd); check("t1_len0_status", rd, 32'h00020001);
    axi_write(4'h0, 32'h0, 4'hF);
    drain_and_stop("t1");

    // ---- 2: SEED=0xAB, FRAME_LEN=3, free-running sink ----
    axi_write(4'h4, 32'hAB, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    exp_d[0] = 32'hABABABAB; exp_l[0] = 1'b0;
    exp_d[1] = 32'h00000000; exp_l[1] = 1'b0;
    exp_d[2] = 32'h00000000; exp_l[2] = 1'b1;
    collect(3, 1'b0, "t2");
    m_axis_tready = 1'b0;
    axi_read(4'hC, rd); check("t2_status", rd, 32'h00010001);
    axi_write(4'h0, 32'h0, 4'hF);
    drain_and_stop("t2");

    // ---- 3: same frame with tready toggling ----
    axi_write(4'h0, 32'h3, 4'hF);
    collect(3, 1'b1, "t3");
    m_axis_tready = 1'b0;
    axi_write(4'h0, 32'h0, 4'hF);
    drain_and_stop("t3");
    axi_read(4'hC, rd); check("t3_status", rd, 32'h00010000);

    // ---- 4: SEED=0 one-shot, FRAME_LEN=4 ----
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h8, 32'h4, 4'hF);
    axi_write(4'h0, 32'h7, 4'hF);
    exp_d[0] = 32'h00000001; exp_l[0] = 1'b0;
    exp_d[1] = 32'h00000000; exp_l[1] = 1'b0;
    exp_d[2] = 32'h00000000; exp_l[2] = 1'b0;
    exp_d[3] = 32'h36241200; exp_l[3] = 1'b1;
    collect(4, 1'b0, "t4");
    @(negedge ACLK);
    check("t4_stop", 32'(m_axis_tvalid), 32'd0);
    repeat (3) @(negedge ACLK);
    check("t4_stay_done", 32'(m_axis_tvalid), 32'd0);
    axi_read(4'hC, rd); check("t4_status", rd, 32'h00010002);
    axi_read(4'h0, rd); check("t4_ctrl", rd, 32'h5);
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'hC, rd); check("t4_status_load", rd, 32'h0);

    // ---- 5: ENABLE cleared mid-frame with a held beat, then resume ----
    axi_write(4'h0, 32'h3, 4'hF);
    collect(2, 1'b0, "t5");
    m_axis_tready = 1'b0;
    @(negedge ACLK);
    check("t5_pend_valid", 32'(m_axis_tvalid), 32'd1);
    check("t5_pend_data", m_axis_tdata, 32'h0);
    axi_write(4'h0, 32'h0, 4'hF);
    check("t5_still_valid", 32'(m_axis_tvalid), 32'd1);
    check("t5_still_last", 32'(m_axis_tlast), 32'd0);
    drain_and_stop("t5");
    axi_write(4'h0, 32'h1, 4'hF);
    @(negedge ACLK);
    check("t5_resume_valid", 32'(m_axis_tvalid), 32'd1);
    check("t5_resume_data", m_axis_tdata, 32'h36241200);
    check("t5_resume_last", 32'(m_axis_tlast), 32'd1);

    // ---- 6: asynchronous reset while a tlast beat is held ----
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_async_tlast", 32'(m_axis_tlast), 32'd0);
    check("t6_async_tdata", m_axis_tdata, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    axi_read(4'h0, rd); check("t6_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("t6_seed", rd, 32'h1);
    axi_read(4'h8, rd); check("t6_len", rd, 32'h1);
    axi_read(4'hC, rd); check("t6_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
